// File: rtl/cpu_run_controller.sv
// Run controller: pulses the cpu reset, watches the PC for a stall or a cycle budget, then freezes the cpu.
// Optional breakpoint comparator enabled with `define CPU_RUN_BREAKPOINT_EN.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cpu held in reset, waiting for START
// RST   | cpu reset pulse, RST_PULSE_CYC cycles long
// RUN   | cpu released, cycle counter and stall detector active
// DONE  | cpu frozen in reset, HALTED/TIMEOUT (or BP_HIT) report why
module cpu_run_controller #(
    parameter int PC_WIDTH      = 32,
    parameter int CNT_WIDTH     = 16,
    parameter int RST_PULSE_CYC = 2,
    parameter int HALT_CYC      = 8,
    parameter int MAX_CYC       = 600
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 START,
    input  logic                 ABORT,
    input  logic [PC_WIDTH-1:0]  PC_IN,
`ifdef CPU_RUN_BREAKPOINT_EN
    input  logic [PC_WIDTH-1:0]  BP_ADDR,
    input  logic                 BP_VALID,
    output logic                 BP_HIT,
`endif
    output logic                 CPU_RESET,
    output logic                 RUNNING,
    output logic                 DONE,
    output logic                 HALTED,
    output logic                 TIMEOUT,
    output logic [CNT_WIDTH-1:0] CYCLE_COUNT
);

    localparam int PW = (RST_PULSE_CYC > 1) ? $clog2(RST_PULSE_CYC) : 1;
    localparam int SW = $clog2(HALT_CYC + 1);

    localparam logic [PW-1:0]        PULSE_LOAD = PW'(RST_PULSE_CYC - 1);
    localparam logic [SW-1:0]        HALT_LAST  = SW'(HALT_CYC - 1);
    localparam logic [CNT_WIDTH-1:0] MAX_COUNT  = CNT_WIDTH'(MAX_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [PW-1:0]          pulse_cnt, pulse_nxt;
    logic [SW-1:0]          stall_cnt, stall_nxt, stall_inc;
    logic [PC_WIDTH-1:0]    last_pc, last_pc_nxt;
    logic [CNT_WIDTH-1:0]   count_nxt, count_inc;
    logic                   halted_nxt, timeout_nxt;
    logic                   bp_hit_q, bp_hit_nxt;
    logic                   bp_match;

`ifdef CPU_RUN_BREAKPOINT_EN
    assign bp_match = BP_VALID && (PC_IN == BP_ADDR);
    assign BP_HIT   = bp_hit_q;
`else
    assign bp_match = 1'b0;
`endif

    // Outputs decode the state register only, so no input reaches an output combinationally.
    assign CPU_RESET = (state != S_RUN);
    assign RUNNING   = (state == S_RUN);
    assign DONE      = (state == S_DONE);

    assign stall_inc = (PC_IN == last_pc) ? stall_cnt + 1'b1 : '0;
    assign count_inc = (&CYCLE_COUNT) ? CYCLE_COUNT : CYCLE_COUNT + 1'b1;

    always_comb begin
        state_nxt   = state;
        pulse_nxt   = pulse_cnt;
        stall_nxt   = stall_cnt;
        last_pc_nxt = last_pc;
        count_nxt   = CYCLE_COUNT;
        halted_nxt  = HALTED;
        timeout_nxt = TIMEOUT;
        bp_hit_nxt  = bp_hit_q;

        if (ABORT) begin
            state_nxt   = S_IDLE;
            halted_nxt  = 1'b0;
            timeout_nxt = 1'b0;
            bp_hit_nxt  = 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        state_nxt   = S_RST;
                        pulse_nxt   = PULSE_LOAD;
                        count_nxt   = '0;
                        halted_nxt  = 1'b0;
                        timeout_nxt = 1'b0;
                        bp_hit_nxt  = 1'b0;
                    end
                end
                S_RST: begin
                    if (pulse_cnt == '0) begin
                        state_nxt   = S_RUN;
                        stall_nxt   = '0;
                        last_pc_nxt = PC_IN;
                    end else begin
                        pulse_nxt = pulse_cnt - 1'b1;
                    end
                end
                S_RUN: begin
                    count_nxt   = count_inc;
                    stall_nxt   = stall_inc;
                    last_pc_nxt = PC_IN;
                    // Breakpoint beats halt, halt beats timeout.
                    if (bp_match) begin
                        state_nxt  = S_DONE;
                        bp_hit_nxt = 1'b1;
                    end else if (stall_inc == HALT_LAST) begin
                        state_nxt  = S_DONE;
                        halted_nxt = 1'b1;
                    end else if (count_inc >= MAX_COUNT) begin
                        state_nxt   = S_DONE;
                        timeout_nxt = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            pulse_cnt   <= '0;
            stall_cnt   <= '0;
            last_pc     <= '0;
            CYCLE_COUNT <= '0;
            HALTED      <= 1'b0;
            TIMEOUT     <= 1'b0;
            bp_hit_q    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pulse_cnt   <= pulse_nxt;
            stall_cnt   <= stall_nxt;
            last_pc     <= last_pc_nxt;
            CYCLE_COUNT <= count_nxt;
            HALTED      <= halted_nxt;
            TIMEOUT     <= timeout_nxt;
            bp_hit_q    <= bp_hit_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: reset pulse, halt, timeout, tie, abort, restart and async reset.
module tb_cpu_run_controller;

    logic        clk_sys = 1'b0;
    logic        rst_b;
    logic        start, abort;
    logic [31:0] pc;
    logic        cpu_reset, running, done, halted, timeout;
    logic [15:0] cycle_count;

    logic        start2, abort2;
    logic [31:0] pc2;
    logic        cpu_reset2, running2, done2, halted2, timeout2;
    logic [15:0] cycle_count2;

`ifdef CPU_RUN_BREAKPOINT_EN
    logic [31:0] bp_addr, bp_addr2;
    logic        bp_valid, bp_valid2, bp_hit, bp_hit2;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk_sys = ~clk_sys;

    cpu_run_controller u_dut (
        .CLK         (clk_sys),
        .RESET_N     (rst_b),
        .START       (start),
        .ABORT       (abort),
        .PC_IN       (pc),
`ifdef CPU_RUN_BREAKPOINT_EN
        .BP_ADDR     (bp_addr),
        .BP_VALID    (bp_valid),
        .BP_HIT      (bp_hit),
`endif
        .CPU_RESET   (cpu_reset),
        .RUNNING     (running),
        .DONE        (done),
        .HALTED      (halted),
        .TIMEOUT     (timeout),
        .CYCLE_COUNT (cycle_count)
    );

    // Constant PC: stall reaches 10 and count reaches 10 on the same edge.
    cpu_run_controller #(.HALT_CYC(11), .MAX_CYC(10)) u_tie (
        .CLK         (clk_sys),
        .RESET_N     (rst_b),
        .START       (start2),
        .ABORT       (abort2),
        .PC_IN       (pc2),
`ifdef CPU_RUN_BREAKPOINT_EN
        .BP_ADDR     (bp_addr2),
        .BP_VALID    (bp_valid2),
        .BP_HIT      (bp_hit2),
`endif
        .CPU_RESET   (cpu_reset2),
        .RUNNING     (running2),
        .DONE        (done2),
        .HALTED      (halted2),
        .TIMEOUT     (timeout2),
        .CYCLE_COUNT (cycle_count2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        rst_b  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        pc     = 32'h0;
        start2 = 1'b0;
        abort2 = 1'b0;
        pc2    = 32'h100;
`ifdef CPU_RUN_BREAKPOINT_EN
        bp_addr   = 32'h0;
        bp_valid  = 1'b0;
        bp_addr2  = 32'h0;
        bp_valid2 = 1'b0;
`endif
        repeat (3) step();
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_running",   32'(running),   32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_flags",     32'({halted, timeout}), 32'd0);
        check("rst_count",     32'(cycle_count), 32'd0);
        rst_b = 1'b1;
        step();

        // Reset pulse: two cycles of CPU_RESET after START
        start  = 1'b1;
        start2 = 1'b1;
        step();
        start  = 1'b0;
        start2 = 1'b0;
        check("pulse1_cpu_reset", 32'(cpu_reset), 32'd1);
        check("pulse1_running",   32'(running),   32'd0);
        step();
        check("pulse2_cpu_reset", 32'(cpu_reset), 32'd1);
        step();
        check("run_cpu_reset", 32'(cpu_reset), 32'd0);
        check("run_running",   32'(running),   32'd1);
        check("run_count0",    32'(cycle_count), 32'd0);

        // Halt: PC steps by 4 up to 0x50, then holds
        for (int i = 1; i <= 20; i++) begin
            pc    = 32'(4 * i);
            start = (i == 12);
            step();
            if (i == 1) check("run_count1", 32'(cycle_count), 32'd1);
            if (i == 9) begin
                check("tie_running9", 32'(running2), 32'd1);
                check("tie_count9",   32'(cycle_count2), 32'd9);
            end
            if (i == 12) begin
                check("start_in_run_running", 32'(running), 32'd1);
                check("start_in_run_count",   32'(cycle_count), 32'd12);
            end
        end
        start = 1'b0;
        check("tie_done",    32'(done2),   32'd1);
        check("tie_halted",  32'(halted2), 32'd1);
        check("tie_timeout", 32'(timeout2), 32'd0);
        check("tie_count",   32'(cycle_count2), 32'd10);
        repeat (6) step();
        check("halt_pre_running", 32'(running), 32'd1);
        check("halt_pre_count",   32'(cycle_count), 32'd26);
        step();
        check("halt_done",      32'(done),      32'd1);
        check("halt_halted",    32'(halted),    32'd1);
        check("halt_timeout",   32'(timeout),   32'd0);
        check("halt_count",     32'(cycle_count), 32'd27);
        check("halt_cpu_reset", 32'(cpu_reset), 32'd1);
        step();
        check("halt_hold_count", 32'(cycle_count), 32'd27);

        // Restart from DONE, then timeout with an ever-changing PC
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_done",   32'(done),   32'd0);
        check("restart_halted", 32'(halted), 32'd0);
        check("restart_count",  32'(cycle_count), 32'd0);
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        step();
        check("restart_pulse2", 32'(cpu_reset), 32'd1);
        step();
        check("restart_running", 32'(running), 32'd1);
        for (int i = 1; i <= 599; i++) begin
            pc = 32'h1000 + 32'(4 * i);
            step();
        end
        check("to_pre_running", 32'(running), 32'd1);
        check("to_pre_count",   32'(cycle_count), 32'd599);
        pc = 32'h2000;
        step();
        check("to_done",    32'(done),    32'd1);
        check("to_timeout", 32'(timeout), 32'd1);
        check("to_halted",  32'(halted),  32'd0);
        check("to_count",   32'(cycle_count), 32'd600);

        // ABORT wins over START in DONE
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("abort_done_done",    32'(done),    32'd0);
        check("abort_done_timeout", 32'(timeout), 32'd0);
        check("abort_done_count",   32'(cycle_count), 32'd600);
        check("abort_done_cpu_reset", 32'(cpu_reset), 32'd1);
        step();
        check("abort_idle_running", 32'(running), 32'd0);

        // ABORT after five RUN cycles
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        for (int i = 1; i <= 5; i++) begin
            pc = 32'h3000 + 32'(4 * i);
            step();
        end
        check("abort_run_pre_count", 32'(cycle_count), 32'd5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_run_running",   32'(running),   32'd0);
        check("abort_run_cpu_reset", 32'(cpu_reset), 32'd1);
        check("abort_run_done",      32'(done),      32'd0);
        check("abort_run_count",     32'(cycle_count), 32'd5);

        // Asynchronous reset between clock edges during RUN
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        pc = 32'h4000;
        step();
        pc = 32'h4004;
        step();
        check("async_pre_count", 32'(cycle_count), 32'd2);
        #2;
        rst_b = 1'b0;
        #1;
        check("async_cpu_reset", 32'(cpu_reset), 32'd1);
        check("async_running",   32'(running),   32'd0);
        check("async_count",     32'(cycle_count), 32'd0);
        step();
        rst_b = 1'b1;
        step();

`ifdef CPU_RUN_BREAKPOINT_EN
        check("bp_reset", 32'(bp_hit), 32'd0);
        bp_addr  = 32'h20;
        bp_valid = 1'b1;
        pc       = 32'h0;
        start    = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        for (int i = 1; i <= 7; i++) begin
            pc = 32'(4 * i);
            step();
        end
        check("bp_pre_running", 32'(running), 32'd1);
        pc = 32'h20;
        step();
        check("bp_done",   32'(done),   32'd1);
        check("bp_hit",    32'(bp_hit), 32'd1);
        check("bp_halted", 32'(halted), 32'd0);
        check("bp_count",  32'(cycle_count), 32'd8);
        bp_valid = 1'b0;
        pc       = 32'h0;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("bp_cleared", 32'(bp_hit), 32'd0);
        step();
        step();
        for (int i = 1; i <= 10; i++) begin
            pc = 32'(4 * i);
            step();
        end
        check("bp_off_running", 32'(running), 32'd1);
        check("bp_off_hit",     32'(bp_hit),  32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
